// File: rtl/sdr_hold_arbiter.sv
// Round-robin arbiter that shares the SDRAM controller's hold/holda burst port
// between the write (master 0) and read (master 1) burst engines, with protocol error flagging.
module sdr_hold_arbiter #(
   parameter int BL_W      = 9,
   parameter int ADDR_W    = 22,
   parameter int DQ_W      = 16,
   parameter int MAX_GRANT = 1023
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              m0_hold,
   input  logic [BL_W-1:0]   m0_length,
   input  logic [ADDR_W-1:0] m0_address,
   input  logic [DQ_W-1:0]   m0_data,
   input  logic              m0_wr,
   output logic              m0_holda,
   input  logic              m1_hold,
   input  logic [BL_W-1:0]   m1_length,
   input  logic [ADDR_W-1:0] m1_address,
   input  logic [DQ_W-1:0]   m1_data,
   input  logic              m1_wr,
   output logic              m1_holda,
   output logic              hold,
   output logic [BL_W-1:0]   burst_length,
   output logic [ADDR_W-1:0] burst_address,
   output logic [DQ_W-1:0]   burst_data,
   output logic              burst_wr,
   input  logic              holda,
   output logic              grant_id,
   output logic              error
);

   localparam int CNT_W = (MAX_GRANT > 0) ? $clog2(MAX_GRANT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MAX_GRANT > 0) ? MAX_GRANT - 1 : 0);
   localparam logic [CNT_W-1:0] CNT_SAT  = '1;

   typedef enum logic [2:0] {
      IDLE    = 3'b001,
      GRANT   = 3'b010,
      RELEASE = 3'b100
   } state_t;

   state_t           state_reg, state_next;
   logic             hold_reg, hold_next;
   logic             grant_id_reg, grant_id_next;
   logic             last_reg, last_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [1:0]       stray_reg, stray_next;
   logic             error_reg, error_next;

   logic granted_hold;
   logic stray_cond;
   logic cnt_hit;

   assign granted_hold = grant_id_reg ? m1_hold : m0_hold;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= IDLE;
         hold_reg     <= 1'b0;
         grant_id_reg <= 1'b0;
         last_reg     <= 1'b1;   // pretend master 1 was served last so master 0 wins the first tie
         cnt_reg      <= '0;
         stray_reg    <= '0;
         error_reg    <= 1'b0;
      end else begin
         state_reg    <= state_next;
         hold_reg     <= hold_next;
         grant_id_reg <= grant_id_next;
         last_reg     <= last_next;
         cnt_reg      <= cnt_next;
         stray_reg    <= stray_next;
         error_reg    <= error_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      grant_id_next = grant_id_reg;
      unique case (state_reg)
         IDLE: begin
            if (m0_hold || m1_hold) begin
               state_next = GRANT;
               if (m0_hold && m1_hold) begin
                  grant_id_next = ~last_reg;
               end else begin
                  grant_id_next = m1_hold;
               end
            end
         end
         GRANT: begin
            if (!granted_hold) begin
               state_next = RELEASE;
            end
         end
         RELEASE: begin
            if (!holda) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Bookkeeping registers: request register, priority, grant timer, error detection.
   always_comb begin
      hold_next  = (state_reg == GRANT) && granted_hold;
      last_next  = last_reg;
      cnt_next   = cnt_reg;
      stray_next = '0;

      if ((state_reg == RELEASE) && !holda) begin
         last_next = grant_id_reg;
      end

      if ((state_reg == IDLE) && (state_next == GRANT)) begin
         cnt_next = '0;
      end else if ((state_reg == GRANT) && (cnt_reg != CNT_SAT)) begin
         cnt_next = cnt_reg + 1'b1;
      end

      stray_cond = holda && !hold_reg && (state_reg != RELEASE);
      if (stray_cond) begin
         stray_next = (stray_reg == 2'd3) ? 2'd3 : stray_reg + 2'd1;
      end

      // The counter reaches MAX_GRANT at the edge closing this grant cycle.
      cnt_hit = (MAX_GRANT != 0) && (state_reg == GRANT) && (cnt_reg == CNT_LAST);

      error_next = error_reg
                 | (holda && (state_reg == IDLE))
                 | cnt_hit
                 | (stray_cond && (stray_reg >= 2'd2));
   end

   always_comb begin
      hold          = hold_reg;
      grant_id      = grant_id_reg;
      error         = error_reg;
      m0_holda      = holda && (state_reg == GRANT) && !grant_id_reg;
      m1_holda      = holda && (state_reg == GRANT) && grant_id_reg;
      burst_length  = '0;
      burst_address = '0;
      burst_data    = '0;
      burst_wr      = 1'b0;
      if (state_reg != IDLE) begin
         if (grant_id_reg) begin
            burst_length  = m1_length;
            burst_address = m1_address;
            burst_data    = m1_data;
            burst_wr      = m1_wr;
         end else begin
            burst_length  = m0_length;
            burst_address = m0_address;
            burst_data    = m0_data;
            burst_wr      = m0_wr;
         end
      end
   end

endmodule

// File: tb/tb_sdr_hold_arbiter.sv
// Bench for sdr_hold_arbiter: directed protocol scenarios then randomized traffic,
// all outputs compared every cycle against a behavioural model of the arbitration rules.
module tb_sdr_hold_arbiter;

   localparam int BL_W   = 9;
   localparam int ADDR_W = 22;
   localparam int DQ_W   = 16;
   localparam int MAXG   = 16;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              m0_hold = 1'b0, m1_hold = 1'b0;
   logic [BL_W-1:0]   m0_length = '0, m1_length = '0;
   logic [ADDR_W-1:0] m0_address = '0, m1_address = '0;
   logic [DQ_W-1:0]   m0_data = '0, m1_data = '0;
   logic              m0_wr = 1'b0, m1_wr = 1'b0;
   logic              holda = 1'b0;
   logic              m0_holda, m1_holda, hold, burst_wr, grant_id, error;
   logic [BL_W-1:0]   burst_length;
   logic [ADDR_W-1:0] burst_address;
   logic [DQ_W-1:0]   burst_data;

   int tests = 0;
   int fails = 0;

   // Behavioural model of the arbitration rules
   bit mdl_busy, mdl_rel, mdl_hold, mdl_err;
   int mdl_owner, mdl_last, mdl_cycles, mdl_stray;

   // Controller emulation and random traffic state
   bit auto_ctrl = 1'b0;
   bit glitch = 1'b0;
   int ctrl_delay_max = 0;
   int ctrl_wait = 0;
   bit mh[2];
   int remain[2];

   sdr_hold_arbiter #(
      .BL_W(BL_W), .ADDR_W(ADDR_W), .DQ_W(DQ_W), .MAX_GRANT(MAXG)
   ) dut (
      .clk(clk), .rst(rst),
      .m0_hold(m0_hold), .m0_length(m0_length), .m0_address(m0_address),
      .m0_data(m0_data), .m0_wr(m0_wr), .m0_holda(m0_holda),
      .m1_hold(m1_hold), .m1_length(m1_length), .m1_address(m1_address),
      .m1_data(m1_data), .m1_wr(m1_wr), .m1_holda(m1_holda),
      .hold(hold), .burst_length(burst_length), .burst_address(burst_address),
      .burst_data(burst_data), .burst_wr(burst_wr), .holda(holda),
      .grant_id(grant_id), .error(error)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mdl_busy = 0; mdl_rel = 0; mdl_hold = 0; mdl_err = 0;
      mdl_owner = 0; mdl_last = 1; mdl_cycles = 0; mdl_stray = 0;
   endtask

   task automatic check_outputs();
      logic [31:0] e_len, e_addr, e_data, e_wr;
      e_len = '0; e_addr = '0; e_data = '0; e_wr = '0;
      if (mdl_busy || mdl_rel) begin
         if (mdl_owner == 0) begin
            e_len = 32'(m0_length); e_addr = 32'(m0_address); e_data = 32'(m0_data); e_wr = 32'(m0_wr);
         end else begin
            e_len = 32'(m1_length); e_addr = 32'(m1_address); e_data = 32'(m1_data); e_wr = 32'(m1_wr);
         end
      end
      chk("hold", 32'(hold), 32'(mdl_hold));
      chk("m0_holda", 32'(m0_holda), 32'(holda && mdl_busy && mdl_owner == 0));
      chk("m1_holda", 32'(m1_holda), 32'(holda && mdl_busy && mdl_owner == 1));
      chk("grant_id", 32'(grant_id), 32'(mdl_owner));
      chk("error", 32'(error), 32'(mdl_err));
      chk("burst_length", 32'(burst_length), e_len);
      chk("burst_address", 32'(burst_address), e_addr);
      chk("burst_data", 32'(burst_data), e_data);
      chk("burst_wr", 32'(burst_wr), e_wr);
   endtask

   // Advance the model across one clock edge using the inputs present at that edge.
   task automatic model_step();
      bit idle_now, busy_now, owner_req;
      idle_now  = !mdl_busy && !mdl_rel;
      busy_now  = mdl_busy;
      owner_req = (mdl_owner == 0) ? m0_hold : m1_hold;
      if (idle_now && holda) mdl_err = 1;
      if (busy_now && (mdl_cycles + 1 == MAXG)) mdl_err = 1;
      if (holda && !mdl_hold && !mdl_rel) mdl_stray++;
      else mdl_stray = 0;
      if (mdl_stray > 2) mdl_err = 1;
      if (idle_now) begin
         mdl_hold = 0;
         if (m0_hold || m1_hold) begin
            mdl_busy   = 1;
            mdl_cycles = 0;
            if (m0_hold && m1_hold) mdl_owner = 1 - mdl_last;
            else mdl_owner = m1_hold ? 1 : 0;
         end
      end else if (busy_now) begin
         mdl_cycles++;
         if (owner_req) begin
            mdl_hold = 1;
         end else begin
            mdl_hold = 0; mdl_busy = 0; mdl_rel = 1;
         end
      end else begin
         mdl_hold = 0;
         if (!holda) begin
            mdl_rel  = 0;
            mdl_last = mdl_owner;
         end
      end
   endtask

   task automatic drive_ctrl();
      if (auto_ctrl) begin
         if (holda != mdl_hold) begin
            if (ctrl_wait == 0) begin
               holda     = mdl_hold;
               ctrl_wait = $urandom_range(0, ctrl_delay_max);
            end else begin
               ctrl_wait--;
            end
         end
         if (glitch && ($urandom_range(0, 9) == 0)) holda = 1'b1;
      end
   endtask

   task automatic tick();
      drive_ctrl();
      #1;
      check_outputs();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #2;
      chk("rst_hold", 32'(hold), 32'd0);
      chk("rst_m0_holda", 32'(m0_holda), 32'd0);
      chk("rst_m1_holda", 32'(m1_holda), 32'd0);
      chk("rst_grant_id", 32'(grant_id), 32'd0);
      chk("rst_error", 32'(error), 32'd0);
      chk("rst_address", 32'(burst_address), 32'd0);
      m0_hold = 0; m1_hold = 0; holda = 0;
      mh[0] = 0; mh[1] = 0; remain[0] = 0; remain[1] = 0;
      ctrl_wait = 0;
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic wait_grant(input int who, input string tag);
      for (int k = 0; k < 20; k++) begin
         drive_ctrl();
         #1;
         if ((who == 0) ? m0_holda : m1_holda) break;
         tick();
      end
      chk({tag, "_holda"}, 32'((who == 0) ? m0_holda : m1_holda), 32'd1);
      chk({tag, "_grant_id"}, 32'(grant_id), 32'(who));
   endtask

   task automatic rand_masters(input int long_max);
      for (int i = 0; i < 2; i++) begin
         if (mh[i]) begin
            remain[i]--;
            if (remain[i] <= 0) mh[i] = 0;
         end else if ($urandom_range(0, 2) == 0) begin
            mh[i]     = 1;
            remain[i] = $urandom_range(1, long_max);
         end
      end
      m0_hold = mh[0]; m1_hold = mh[1];
      m0_length = BL_W'($urandom); m1_length = BL_W'($urandom);
      m0_address = ADDR_W'($urandom); m1_address = ADDR_W'($urandom);
      m0_data = DQ_W'($urandom); m1_data = DQ_W'($urandom);
      m0_wr = 1'($urandom); m1_wr = 1'($urandom);
   endtask

   initial begin
      model_reset();
      @(posedge clk);
      #1;
      do_reset();

      // Single requester: hold one cycle after grant, fields muxed, holda routed to m0 only
      auto_ctrl = 0;
      m0_hold = 1; m0_length = 9'd8; m0_address = 22'h100; m0_data = 16'hbeef; m0_wr = 1;
      m1_address = 22'h2aa; m1_length = 9'd3;
      tick();
      tick();
      chk("t1_hold", 32'(hold), 32'd1);
      chk("t1_addr", 32'(burst_address), 32'h100);
      chk("t1_len", 32'(burst_length), 32'd8);
      holda = 1;
      #1;
      chk("t1_m0_holda", 32'(m0_holda), 32'd1);
      chk("t1_m1_holda", 32'(m1_holda), 32'd0);
      tick(); tick();
      m0_hold = 0;
      tick(); tick(); tick();
      chk("t1_rel_hold", 32'(hold), 32'd0);
      holda = 0;
      tick(); tick();

      // Simultaneous requests, then continuous requests alternating over four grants
      do_reset();
      auto_ctrl = 1; ctrl_delay_max = 2;
      m0_hold = 1; m1_hold = 1;
      m0_address = 22'h111; m1_address = 22'h222;
      for (int g = 0; g < 4; g++) begin
         wait_grant(g % 2, "t3_alt");
         tick(); tick();
         if (g % 2 == 0) m0_hold = 0; else m1_hold = 0;
         tick();
         if (g % 2 == 0) m0_hold = 1; else m1_hold = 1;
      end
      m0_hold = 0; m1_hold = 0;
      repeat (6) tick();

      // Stray holda in IDLE sets a sticky error
      do_reset();
      auto_ctrl = 0;
      holda = 1;
      tick();
      chk("t4_err", 32'(error), 32'd1);
      holda = 0;
      repeat (3) tick();
      chk("t4_sticky", 32'(error), 32'd1);

      // Over-long grant flags at cycle MAXG, arbitration carries on
      do_reset();
      auto_ctrl = 1; ctrl_delay_max = 0;
      m1_hold = 1;
      tick();
      for (int k = 1; k <= MAXG; k++) begin
         tick();
         if (k == MAXG - 1) chk("t5_err_early", 32'(error), 32'd0);
      end
      chk("t5_err_at_max", 32'(error), 32'd1);
      repeat (4) tick();
      m1_hold = 0; m0_hold = 1;
      wait_grant(0, "t5_next");
      chk("t5_err_kept", 32'(error), 32'd1);

      // Reset mid-grant restores master 0 priority
      m0_hold = 0; m1_hold = 1;
      wait_grant(1, "t6_pre");
      tick(); tick();
      chk("t6_holda_high", 32'(holda), 32'd1);
      do_reset();
      auto_ctrl = 1;
      m0_hold = 1; m1_hold = 1;
      wait_grant(0, "t6_post");
      m0_hold = 0; m1_hold = 0;
      repeat (6) tick();

      // Randomized traffic against the model
      for (int seg = 0; seg < 12; seg++) begin
         do_reset();
         auto_ctrl      = 1;
         ctrl_delay_max = $urandom_range(0, 3);
         glitch         = (seg % 3 == 2);
         for (int c = 0; c < 60; c++) begin
            rand_masters((seg % 4 == 3) ? 24 : 8);
            tick();
         end
         glitch = 0;
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
